// File: rtl/csel_div_pkg.sv
// Shared types and constants for the carry-select sequential divider.
// Optional signed operation is enabled with the CSEL_DIV_SIGNED_EN macro.
package csel_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    // Wide enough for any practical WIDTH; sliced to WIDTH at the use site.
    localparam logic [63:0] DIV_ZERO_QUOTIENT = '1;

endpackage

// File: rtl/csel_sub.sv
// (WIDTH+1)-bit carry-select subtractor: CHUNK-bit groups precompute both
// borrow-in cases, the incoming borrow selects; the MSB is a 1-bit stage.
module csel_sub
    import csel_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    input  logic           borrow_in,
    output logic [WIDTH:0] diff,
    output logic           borrow_out
);

    localparam int GROUPS = WIDTH / CHUNK;

    logic [GROUPS:0] bchain;

    assign bchain[0] = borrow_in;

    for (genvar g = 0; g < GROUPS; g++) begin : g_grp
        logic [CHUNK:0] d0;
        logic [CHUNK:0] d1;

        // Bit CHUNK of each extended difference is that case's borrow-out.
        assign d0 = {1'b0, a[g*CHUNK +: CHUNK]} - {1'b0, b[g*CHUNK +: CHUNK]};
        assign d1 = {1'b0, a[g*CHUNK +: CHUNK]} - {1'b0, b[g*CHUNK +: CHUNK]}
                    - (CHUNK+1)'(1);

        assign diff[g*CHUNK +: CHUNK] = bchain[g] ? d1[CHUNK-1:0] : d0[CHUNK-1:0];
        assign bchain[g+1]            = bchain[g] ? d1[CHUNK]     : d0[CHUNK];
    end

    assign diff[WIDTH] = a[WIDTH] ^ b[WIDTH] ^ bchain[GROUPS];
    assign borrow_out  = (~a[WIDTH] & b[WIDTH]) |
                         (~(a[WIDTH] ^ b[WIDTH]) & bchain[GROUPS]);

endmodule

// File: rtl/csel_seq_divider.sv
// Restoring divider retiring one quotient bit per cycle, valid/ready on both sides.
// Define CSEL_DIV_SIGNED_EN to add the signed_mode port (truncating signed division).
module csel_seq_divider
    import csel_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef CSEL_DIV_SIGNED_EN
    input  logic             signed_mode,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             dz_pend;
    logic             neg_q;
    logic             neg_r;

    logic [WIDTH-1:0] q_sh;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH:0]   r_reg;

    logic             accept;
    logic             sm;
    logic             div_zero_in;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;
    logic             unused_r_msb;

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                   input logic en);
        return (en && v[WIDTH-1]) ? WIDTH'(-v) : WIDTH'(v);
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                    input logic neg);
        return neg ? WIDTH'(-v) : v;
    endfunction

`ifdef CSEL_DIV_SIGNED_EN
    assign sm = signed_mode;
`else
    assign sm = 1'b0;
`endif

    assign accept      = in_valid && in_ready;
    assign div_zero_in = (divisor == '0);
    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);

    // The partial remainder never exceeds the divisor, so its top bit stays clear.
    assign trial        = {r_reg[WIDTH-1:0], q_sh[WIDTH-1]};
    assign unused_r_msb = r_reg[WIDTH];

    csel_sub #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) u_sub (
        .a          (trial),
        .b          ({1'b0, d_reg}),
        .borrow_in  (1'b0),
        .diff       (diff),
        .borrow_out (borrow)
    );

    assign r_next = borrow ? trial : diff;
    assign q_next = {q_sh[WIDTH-2:0], ~borrow};

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = CALC;
            CALC:    if (dz_pend || cnt == '0) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Zero divisor spends one CALC cycle as a bypass so its result lands one edge after accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            dz_pend     <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                dz_pend <= div_zero_in;
                cnt     <= div_zero_in ? '0 : CNT_W'(WIDTH - 1);
                neg_q   <= sm && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                neg_r   <= sm && dividend[WIDTH-1];
            end else if (state == CALC) begin
                if (dz_pend) begin
                    quotient    <= DIV_ZERO_QUOTIENT[WIDTH-1:0];
                    remainder   <= q_sh;
                    div_by_zero <= 1'b1;
                end else if (cnt == '0) begin
                    quotient    <= apply_sign(q_next, neg_q);
                    remainder   <= apply_sign(r_next[WIDTH-1:0], neg_r);
                    div_by_zero <= 1'b0;
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
            end
        end
    end

    // Datapath registers are fully loaded on accept and need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            q_sh  <= div_zero_in ? dividend : magnitude(dividend, sm);
            d_reg <= magnitude(divisor, sm);
            r_reg <= '0;
        end else if (state == CALC && !dz_pend) begin
            q_sh  <= q_next;
            r_reg <= r_next;
        end
    end

endmodule

// File: tb/tb_csel_seq_divider.sv
// Directed self-checking bench for csel_seq_divider (WIDTH=16, CHUNK=4).
module tb_csel_seq_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
`ifdef CSEL_DIV_SIGNED_EN
    logic        signed_mode = 1'b0;
`endif
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    always #5 clk = ~clk;

    csel_seq_divider #(.WIDTH(16), .CHUNK(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
`ifdef CSEL_DIV_SIGNED_EN
        .signed_mode (signed_mode),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Called at a negedge; returns at the negedge where out_valid is first seen.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, output int lat,
                          output int busy_ready);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("ready_wait", in_ready, 1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid   = 1'b0;
        dividend   = 16'hA5A5;
        divisor    = 16'h0000;
        lat        = 0;
        busy_ready = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_ready++;
            @(negedge clk);
            lat++;
        end
        if (in_ready) busy_ready++;
    endtask

    initial begin
        int lat;
        int busy;

        vecs[0]  = '{16'd100,   16'd7,      16'd14,     16'd2,      1'b0, 16};
        vecs[1]  = '{16'hFFFF,  16'h0001,   16'hFFFF,   16'h0000,   1'b0, 16};
        vecs[2]  = '{16'h0003,  16'hFFFF,   16'h0000,   16'h0003,   1'b0, 16};
        vecs[3]  = '{16'd5,     16'd0,      16'hFFFF,   16'd5,      1'b1, 1};
        vecs[4]  = '{16'd0,     16'd9,      16'd0,      16'd0,      1'b0, 16};
        vecs[5]  = '{16'd9,     16'd4,      16'd2,      16'd1,      1'b0, 16};
        vecs[6]  = '{16'hFFFF,  16'hFFFF,   16'd1,      16'd0,      1'b0, 16};
        vecs[7]  = '{16'hFFFE,  16'hFFFF,   16'd0,      16'hFFFE,   1'b0, 16};
        vecs[8]  = '{16'd50000, 16'd3,      16'd16666,  16'd2,      1'b0, 16};
        vecs[9]  = '{16'd12345, 16'd123,    16'd100,    16'd45,     1'b0, 16};
        vecs[10] = '{16'h8000,  16'h0100,   16'h0080,   16'h0000,   1'b0, 16};
        vecs[11] = '{16'd65535, 16'd256,    16'd255,    16'd255,    1'b0, 16};
        vecs[12] = '{16'h0000,  16'h0000,   16'hFFFF,   16'h0000,   1'b1, 1};

        // Reset state
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back table run with out_ready held high
        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].a, vecs[i].b, lat, busy);
            check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            check($sformatf("v%0d_busy_ready", i), busy, 0);
            check($sformatf("v%0d_q", i), quotient, vecs[i].q);
            check($sformatf("v%0d_r", i), remainder, vecs[i].r);
            check($sformatf("v%0d_dz", i), div_by_zero, vecs[i].dz);
        end
        @(negedge clk);

        // Output held while out_ready is low
        out_ready = 1'b0;
        run_op(16'd1000, 16'd10, lat, busy);
        check("hold_lat", lat, 16);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("hold%0d_valid", c), out_valid, 1);
            check($sformatf("hold%0d_ready", c), in_ready, 0);
            check($sformatf("hold%0d_q", c), quotient, 100);
            check($sformatf("hold%0d_r", c), remainder, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("hs_valid_low", out_valid, 0);
        check("hs_in_ready", in_ready, 1);
        check("hs_q_retained", quotient, 100);

        // Reset in the middle of a calculation
        dividend = 16'd50000;
        divisor  = 16'd3;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 8; c++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_q", quotient, 0);
        check("mid_rst_r", remainder, 0);
        @(negedge clk);
        rst_n = 1'b1;
        busy = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid) busy++;
        end
        check("mid_rst_no_valid", busy, 0);
        run_op(16'd9, 16'd4, lat, busy);
        check("post_rst_lat", lat, 16);
        check("post_rst_q", quotient, 2);
        check("post_rst_r", remainder, 1);
        @(negedge clk);

`ifdef CSEL_DIV_SIGNED_EN
        signed_mode = 1'b1;
        run_op(16'hFF9C, 16'd7, lat, busy);
        check("s_neg_pos_q", quotient, 16'hFFF2);
        check("s_neg_pos_r", remainder, 16'hFFFE);
        check("s_lat", lat, 16);
        run_op(16'h8000, 16'hFFFF, lat, busy);
        check("s_ovf_q", quotient, 16'h8000);
        check("s_ovf_r", remainder, 16'h0000);
        run_op(16'd100, 16'hFFF9, lat, busy);
        check("s_pos_neg_q", quotient, 16'hFFF2);
        check("s_pos_neg_r", remainder, 16'd2);
        run_op(16'hFF9C, 16'hFFF9, lat, busy);
        check("s_neg_neg_q", quotient, 16'd14);
        check("s_neg_neg_r", remainder, 16'hFFFE);
        run_op(16'hFFFB, 16'h0000, lat, busy);
        check("s_dz_q", quotient, 16'hFFFF);
        check("s_dz_r", remainder, 16'hFFFB);
        check("s_dz_flag", div_by_zero, 1);
        check("s_dz_lat", lat, 1);
        @(negedge clk);
        signed_mode = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
